uart_tx_flow: RTL and testbench

- UART transmitter for result bytes going from the BNN back to the host. It is the transmit end of the link whose receive side feeds bnn_controller.
- Buffers bytes pushed by the controller in a small FIFO.
- Serialises each byte as 8N1 on UART_Tx.
- Starts a new frame only while the host grants permission on UART_RTS.

---
 rtl/uart_tx_flow.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_flow.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_flow.sv
// uart_tx_flow
//   UART transmitter for result bytes returning from the BNN to the host.
//   Bytes pushed by the controller are buffered in a small circular FIFO and
//   sent as 8N1 frames (start, 8 data bits LSB first, stop) on UART_Tx.
//   A new frame is only started while the host grants permission on
//   UART_RTS. A frame already on the line always completes.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit period (>= 2)
//   FIFO_DEPTH    transmit FIFO entries (power of 2, >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   tx_data     byte to transmit
//   tx_valid    tx_data valid; push on clk edge when tx_valid && tx_ready
//   tx_ready    FIFO has room for a byte
//   UART_RTS    host permission to send (asynchronous to clk)
//   UART_Tx     serial output, idle high
//   busy        frame on the line or FIFO non-empty
//   fifo_count  number of bytes currently buffered
module uart_tx_flow #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          UART_RTS,
    output logic                          UART_Tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  FULL        = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [BAUD_W-1:0]   baud_cnt, baud_next;
    logic [2:0]          bit_idx, bit_next;
    logic [7:0]          shift_reg, shift_next;
    logic                tx_next;

    logic                rts_meta, rts_s;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push, pop;

    assign tx_ready   = (count != FULL);
    assign push       = tx_valid && tx_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    // RTS crosses from the host domain: two-flop synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rts_meta <= 1'b0;
            rts_s    <= 1'b0;
        end else begin
            rts_meta <= UART_RTS;
            rts_s    <= rts_meta;
        end
    end

    // FIFO control. Simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries no reset; entries are only read after a push.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // FSM state and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            UART_Tx  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            UART_Tx  <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shift_reg <= shift_next;
    end

    // Next-state logic. UART_Tx is registered from the next state so the
    // line is glitch-free and still falls on the same edge as the pop.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        pop        = 1'b0;
        tx_next    = 1'b1;

        case (state)
            IDLE: begin
                if ((count != '0) && rts_s) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = BAUD_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_next  = BAUD_RELOAD;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_next  = BAUD_RELOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                // Returning to IDLE guarantees at least one idle-high clock
                // before the next start bit.
                if (baud_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_flow.sv
// tb_uart_tx_flow
//   Directed bench for uart_tx_flow with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   A line monitor decodes 8N1 frames from UART_Tx into a byte queue with
//   the start cycle of each frame; the main sequence drives directed
//   stimulus and compares against hand-computed values.
module tb_uart_tx_flow;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       UART_RTS;
    logic       UART_Tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frm_err  = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];

    uart_tx_flow #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .UART_RTS   (UART_RTS),
        .UART_Tx    (UART_Tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: samples at negedge, bit value taken mid-bit.
    initial begin
        int         pos;
        int         st;
        logic [7:0] b;
        pos = -1;
        st  = 0;
        b   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = -1;
            end else if (pos < 0) begin
                if (UART_Tx == 1'b0) begin
                    pos = 1;
                    st  = cyc;
                    b   = 8'h00;
                end
            end else begin
                if (pos < 4) begin
                    if (UART_Tx !== 1'b0) frm_err++;
                end else if (pos < 36) begin
                    if (((pos - 4) % 4) == 2) b[(pos - 4) / 4] = UART_Tx;
                end else begin
                    if (UART_Tx !== 1'b1) frm_err++;
                end
                if (pos == 39) begin
                    rx_q.push_back(b);
                    start_q.push_back(st);
                    pos = -1;
                end else begin
                    pos++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] b);
        logic [31:0] got;
        if (rx_q.size() > 0) got = {24'h0, rx_q.pop_front()};
        else                 got = 32'h100;
        check(tag, got, {24'h0, b});
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, (rx_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        start_q.delete();
    endtask

    initial begin
        logic [7:0] pat;
        int         lows;

        rst      = 1'b1;
        UART_RTS = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        check("rst_tx",    UART_Tx,    1);
        check("rst_ready", tx_ready,   1);
        check("rst_busy",  busy,       0);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        repeat (4) tick();

        // Single frame 0xA5: start, bits LSB first, stop, busy timing.
        clear_rx();
        pat = 8'hA5;
        push(pat);
        check("t1_count_after_push", fifo_count, 1);
        check("t1_idle_before_pop",  UART_Tx,    1);
        tick();
        check("t1_start_low", UART_Tx,    0);
        check("t1_popped",    fifo_count, 0);
        check("t1_busy",      busy,       1);
        for (int b = 0; b < 8; b++) begin
            repeat (4) tick();
            check($sformatf("t1_bit%0d", b), UART_Tx, pat[b]);
        end
        repeat (4) tick();
        check("t1_stop_high", UART_Tx, 1);
        check("t1_busy_stop", busy,    1);
        repeat (3) tick();
        check("t1_busy_last_stop", busy, 1);
        tick();
        check("t1_busy_done", busy,    0);
        check("t1_line_idle", UART_Tx, 1);
        expect_rx("t1_byte", 8'hA5);

        // Four back-to-back pushes: order and one-clock inter-frame gap.
        repeat (3) tick();
        clear_rx();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        check("t2_count3", fifo_count, 3);
        wait_rx("t2_wait", 4, 4 * 41 + 20);
        for (int k = 0; k < 3; k++)
            check($sformatf("t2_gap%0d", k), start_q[k+1] - start_q[k], 41);
        expect_rx("t2_b0", 8'h01);
        expect_rx("t2_b1", 8'h02);
        expect_rx("t2_b2", 8'h03);
        expect_rx("t2_b3", 8'h04);

        // RTS low: fill FIFO, hold a fifth byte, then release RTS.
        repeat (3) tick();
        clear_rx();
        UART_RTS = 1'b0;
        repeat (3) tick();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (5) tick();
        check("t3_full_ready", tx_ready,   0);
        check("t3_full_count", fifo_count, 4);
        check("t3_line_high",  UART_Tx,    1);
        check("t3_busy",       busy,       1);
        UART_RTS = 1'b1;
        tick();
        check("t3_sync1", UART_Tx, 1);
        tick();
        check("t3_sync2", UART_Tx, 1);
        tick();
        check("t3_start_3clk", UART_Tx,    0);
        check("t3_after_pop",  fifo_count, 3);
        tick();
        check("t3_fifth_in", fifo_count, 4);
        tx_valid = 1'b0;
        wait_rx("t3_wait", 5, 5 * 41 + 20);
        expect_rx("t3_b0", 8'h11);
        expect_rx("t3_b1", 8'h22);
        expect_rx("t3_b2", 8'h33);
        expect_rx("t3_b3", 8'h44);
        expect_rx("t3_b4", 8'h55);

        // RTS dropped during bit 3 of the first frame.
        repeat (3) tick();
        clear_rx();
        push(8'h3C);
        push(8'hC3);
        repeat (17) tick();
        UART_RTS = 1'b0;
        repeat (30) tick();
        check("t4_held_count", fifo_count, 1);
        check("t4_line_high",  UART_Tx,    1);
        check("t4_busy",       busy,       1);
        repeat (100) tick();
        check("t4_one_frame", rx_q.size(), 1);
        expect_rx("t4_b0", 8'h3C);
        check("t4_still_held", fifo_count, 1);
        UART_RTS = 1'b1;
        wait_rx("t4_wait", 1, 60);
        expect_rx("t4_b1", 8'hC3);

        // Asynchronous reset mid-frame.
        repeat (3) tick();
        clear_rx();
        push(8'hFF);
        push(8'h00);
        repeat (8) tick();
        check("t5_pre_count", fifo_count, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_tx",    UART_Tx,    1);
        check("t5_async_count", fifo_count, 0);
        check("t5_async_busy",  busy,       0);
        check("t5_async_ready", tx_ready,   1);
        tick();
        tick();
        rst  = 1'b0;
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (UART_Tx !== 1'b1) lows++;
        end
        check("t5_no_line_low", lows,        0);
        check("t5_no_frame",    rx_q.size(), 0);
        check("t5_count",       fifo_count,  0);

        // Push on the same edge as an IDLE pop with two bytes buffered.
        clear_rx();
        UART_RTS = 1'b0;
        repeat (3) tick();
        push(8'h5A);
        push(8'h96);
        check("t6_count2", fifo_count, 2);
        UART_RTS = 1'b1;
        tick();
        tick();
        tx_data  = 8'h69;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("t6_count_same", fifo_count, 2);
        check("t6_start",      UART_Tx,    0);
        wait_rx("t6_wait", 3, 3 * 41 + 20);
        expect_rx("t6_b0", 8'h5A);
        expect_rx("t6_b1", 8'h96);
        expect_rx("t6_b2", 8'h69);

        check("framing", frm_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
